// File: rtl/ahblite_bram_ws.sv
// AHB-Lite on-chip SRAM slave: byte-lane writes, programmable read wait states,
// write-to-read forwarding and a two-cycle ERROR response. Optional macro AHB_BRAM_WPROT_EN.
module ahblite_bram_ws #(
    parameter int ADDR_WIDTH  = 14,
    parameter int MEM_WORDS   = 16384,
    parameter int RD_WAIT     = 0,
    parameter int WPROT_WORDS = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);
    typedef enum logic [1:0] {ST_IDLE, ST_RWAIT, ST_ERR1, ST_ERR2} state_t;

    localparam logic [1:0] WAIT_CNT = 2'(RD_WAIT);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx, widx_q;
    logic [3:0]            strb, wstrb_q, fwd_strb_q;
    logic                  misalign, size_bad, range_bad, prot_bad, illegal;
    logic                  acc, rd_en, wr_pend_q, rd_vld_q;
    logic [31:0]           mem_rd_q, fwd_data_q, rd_word;
    logic [31:0]           mem [0:(2**ADDR_WIDTH)-1];

    assign acc = HSEL & HTRANS[1] & HREADY;
    assign idx = HADDR[ADDR_WIDTH+1:2];

    always_comb begin
        strb     = 4'b0000;
        misalign = 1'b0;
        case ({HADDR[1:0], HSIZE[1:0]})
            4'h0:    strb = 4'b0001;
            4'h1:    strb = 4'b0011;
            4'h2:    strb = 4'b1111;
            4'h4:    strb = 4'b0010;
            4'h8:    strb = 4'b0100;
            4'h9:    strb = 4'b1100;
            4'hC:    strb = 4'b1000;
            default: misalign = 1'b1;
        endcase
    end

    assign size_bad  = (HSIZE > 3'd2);
    assign range_bad = (32'(idx) >= 32'(MEM_WORDS));

`ifdef AHB_BRAM_WPROT_EN
    assign prot_bad = HWRITE & ~HPROT[1] & (32'(idx) < 32'(WPROT_WORDS));
`else
    assign prot_bad = 1'b0;
`endif

    assign illegal = misalign | size_bad | range_bad | prot_bad;
    assign rd_en   = acc & ~HWRITE & ~illegal;

    logic unused_ok;
    assign unused_ok = &{1'b0, HPROT, HTRANS[0], HADDR[31:ADDR_WIDTH+2], rd_vld_q,
                         (WPROT_WORDS < 0)};

    // ERR2 completes the error response and accepts a new address phase like IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            ST_RWAIT: begin
                HREADYOUT = 1'b0;
                cnt_d     = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = ST_IDLE;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            default: begin
                if (state_q == ST_ERR2) HRESP = 1'b1;
                state_d = ST_IDLE;
                if (acc && illegal) begin
                    state_d = ST_ERR1;
                end else if (acc && !HWRITE && (RD_WAIT > 0)) begin
                    state_d = ST_RWAIT;
                    cnt_d   = WAIT_CNT;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            wr_pend_q  <= 1'b0;
            widx_q     <= '0;
            wstrb_q    <= 4'b0000;
            fwd_strb_q <= 4'b0000;
            fwd_data_q <= 32'h0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_pend_q <= acc & HWRITE;
            if (acc) begin
                widx_q  <= idx;
                wstrb_q <= (HWRITE && !illegal) ? strb : 4'b0000;
            end
            // A read overlapping the data phase of a write to the same word sees HWDATA.
            if (rd_en) begin
                fwd_strb_q <= (wr_pend_q && (widx_q == idx)) ? wstrb_q : 4'b0000;
                fwd_data_q <= HWDATA;
                rd_vld_q   <= 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_pend_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[widx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
        if (rd_en) mem_rd_q <= mem[idx];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
        assign rd_word[8*gi +: 8] = fwd_strb_q[gi] ? fwd_data_q[8*gi +: 8]
                                                   : mem_rd_q[8*gi +: 8];
    end

    if (RD_WAIT == 0) begin : g_nowait
        assign HRDATA = rd_vld_q ? rd_word : 32'h0;
    end else begin : g_wait
        logic [31:0] hrdata_q;
        // Output register updates only as the read data phase completes.
        always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET) hrdata_q <= 32'h0;
            else if (state_q == ST_RWAIT && cnt_q == 2'd1) hrdata_q <= rd_word;
        end
        assign HRDATA = hrdata_q;
    end
endmodule
